// File: rtl/wb_cmd_master.sv
// Single-transfer Wishbone classic initiator driven by a valid/ready command stream.
// Each command becomes one bus cycle with bounded rty re-issue and a per-attempt timeout.
module wb_cmd_master #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [DW-1:0]   cmd_dat,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_dat,
   output logic [1:0]      rsp_status,
   output logic            busy,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_RTY = 2'b10;
   localparam logic [1:0] ST_TMO = 2'b11;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   logic [1:0]    state_reg;
   logic          we_reg;
   logic [TW-1:0] tmo_cnt_reg;
   logic [RW-1:0] retry_cnt_reg;

   logic          term_finish;
   logic          term_gap;
   logic [1:0]    term_status;
   logic [DW-1:0] term_dat;

   assign wb_cti_o = 3'b000;
   assign wb_bte_o = 2'b00;

   // Outcome of the current BUS cycle; priority ack > err > rty > timeout.
   always_comb begin
      term_finish = 1'b0;
      term_gap    = 1'b0;
      term_status = ST_OK;
      term_dat    = '0;
      if (wb_ack_i) begin
         term_finish = 1'b1;
         term_dat    = we_reg ? '0 : wb_dat_i;
      end else if (wb_err_i) begin
         term_finish = 1'b1;
         term_status = ST_ERR;
      end else if (wb_rty_i) begin
         if (retry_cnt_reg < RETRY_MAX) begin
            term_gap = 1'b1;
         end else begin
            term_finish = 1'b1;
            term_status = ST_RTY;
         end
      end else if (tmo_cnt_reg == TMO_LAST) begin
         term_finish = 1'b1;
         term_status = ST_TMO;
      end
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_reg     <= S_IDLE;
         we_reg        <= 1'b0;
         tmo_cnt_reg   <= '0;
         retry_cnt_reg <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_dat       <= '0;
         rsp_status    <= ST_OK;
         busy          <= 1'b0;
         wb_adr_o      <= '0;
         wb_dat_o      <= '0;
         wb_we_o       <= 1'b0;
         wb_cyc_o      <= 1'b0;
         wb_stb_o      <= 1'b0;
         wb_sel_o      <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state_reg     <= S_BUS;
                  cmd_ready     <= 1'b0;
                  busy          <= 1'b1;
                  we_reg        <= cmd_we;
                  tmo_cnt_reg   <= '0;
                  retry_cnt_reg <= '0;
                  wb_adr_o      <= cmd_adr;
                  wb_dat_o      <= cmd_dat;
                  wb_we_o       <= cmd_we;
                  wb_cyc_o      <= 1'b1;
                  wb_stb_o      <= 1'b1;
                  wb_sel_o      <= '1;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            S_BUS: begin
               if (term_finish || term_gap) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= '0;
               end
               if (term_finish) begin
                  state_reg  <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_dat    <= term_dat;
                  rsp_status <= term_status;
               end else if (term_gap) begin
                  state_reg     <= S_GAP;
                  retry_cnt_reg <= retry_cnt_reg + 1'b1;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            S_GAP: begin
               // Re-issue the latched address/data/we after one idle cycle.
               state_reg   <= S_BUS;
               tmo_cnt_reg <= '0;
               wb_we_o     <= we_reg;
               wb_cyc_o    <= 1'b1;
               wb_stb_o    <= 1'b1;
               wb_sel_o    <= '1;
            end
            default: begin
               if (rsp_ready) begin
                  state_reg <= S_IDLE;
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
